// File: rtl/fc7_layer.sv
// fc7_layer: LeNet F7 fully-connected output layer.
// Ten parallel signed MAC lanes (one per class) share a single read
// address that sweeps the F6 activation memory and the layer-7 weight ROM.
// A sequential argmax over the ten scores then produces the class index.
module fc7_layer #(
   parameter int N_IN   = 84,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic [ADDR_W-1:0]     f6_raddr,
   input  logic [DATA_W-1:0]     f6_rdata,
   output logic [ADDR_W-1:0]     w7_raddr,
   input  logic [DATA_W-1:0]     w7_1_rdata,
   input  logic [DATA_W-1:0]     w7_2_rdata,
   input  logic [DATA_W-1:0]     w7_3_rdata,
   input  logic [DATA_W-1:0]     w7_4_rdata,
   input  logic [DATA_W-1:0]     w7_5_rdata,
   input  logic [DATA_W-1:0]     w7_6_rdata,
   input  logic [DATA_W-1:0]     w7_7_rdata,
   input  logic [DATA_W-1:0]     w7_8_rdata,
   input  logic [DATA_W-1:0]     w7_9_rdata,
   input  logic [DATA_W-1:0]     w7_10_rdata,
   output logic [10*ACC_W-1:0]   fc7_result,
   output logic [3:0]            class_id,
   output logic                  done
);

   localparam int PROD_W = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] ARGMAX = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]                state;
   logic [ADDR_W-1:0]         addr;
   logic                      rd_valid;
   logic [3:0]                arg_k;
   logic signed [DATA_W-1:0]  w [10];
   logic signed [PROD_W-1:0]  prod [10];
   logic signed [ACC_W-1:0]   acc [10];
   logic signed [ACC_W-1:0]   cand_score;
   logic signed [ACC_W-1:0]   best_score;
   logic [3:0]                best_idx;

   assign f6_raddr = addr;
   assign w7_raddr = addr;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // Gather the ten weight ports into an array and form the per-lane products.
   always_comb begin
      w[0] = w7_1_rdata;
      w[1] = w7_2_rdata;
      w[2] = w7_3_rdata;
      w[3] = w7_4_rdata;
      w[4] = w7_5_rdata;
      w[5] = w7_6_rdata;
      w[6] = w7_7_rdata;
      w[7] = w7_8_rdata;
      w[8] = w7_9_rdata;
      w[9] = w7_10_rdata;
      for (int k = 0; k < 10; k++) begin
         prod[k] = $signed(f6_rdata) * w[k];
      end
   end

   // Select the candidate score and the running best; the first argmax step compares against class 0.
   always_comb begin
      best_idx   = (arg_k == 4'd1) ? 4'd0 : class_id;
      cand_score = '0;
      best_score = '0;
      for (int k = 0; k < 10; k++) begin
         if (arg_k == 4'(k)) cand_score = acc[k];
         if (best_idx == 4'(k)) best_score = acc[k];
      end
   end

   // Control FSM: address sweep, read-valid pipe, drain and argmax sequencing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr     <= '0;
         rd_valid <= 1'b0;
         arg_k    <= '0;
         class_id <= '0;
      end else begin
         rd_valid <= (state == RUN);
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  addr  <= '0;
               end
            end
            RUN: begin
               if (addr == LAST_ADDR) state <= DRAIN;
               else                   addr  <= addr + 1'b1;
            end
            DRAIN: begin
               state <= ARGMAX;
               arg_k <= 4'd1;
            end
            ARGMAX: begin
               class_id <= (cand_score > best_score) ? arg_k : best_idx;
               if (arg_k == 4'd9) state <= DONE;
               else               arg_k <= arg_k + 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Accumulators: cleared on reset and on an accepted start, add sign-extended products while data is valid.
   always_ff @(posedge clk) begin
      if (!rst_n || (state == IDLE && start)) begin
         for (int k = 0; k < 10; k++) acc[k] <= '0;
      end else if (rd_valid) begin
         for (int k = 0; k < 10; k++) begin
            acc[k] <= acc[k] + {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
         end
      end
   end

   // Pack the ten class scores onto the result bus.
   always_comb begin
      fc7_result = '0;
      for (int k = 0; k < 10; k++) begin
         fc7_result[k*ACC_W +: ACC_W] = acc[k];
      end
   end

endmodule

// File: tb/tb_fc7_layer.sv
// tb_fc7_layer: scoreboard bench for fc7_layer with 1-cycle-latency memory models.
module tb_fc7_layer;

   localparam int N_IN  = 84;
   localparam int ACC_W = 24;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               busy;
   logic [6:0]         f6_raddr;
   logic [7:0]         f6_rdata;
   logic [6:0]         w7_raddr;
   logic [7:0]         w_rd [10];
   logic [10*ACC_W-1:0] fc7_result;
   logic [3:0]         class_id;
   logic               done;

   logic signed [7:0]  f6_mem [128];
   logic signed [7:0]  w_mem  [10][128];

   typedef struct {
      int score [10];
      int cls;
   } exp_t;

   exp_t sb [$];
   int   vectors;
   int   miscompares;

   fc7_layer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .f6_raddr   (f6_raddr),
      .f6_rdata   (f6_rdata),
      .w7_raddr   (w7_raddr),
      .w7_1_rdata (w_rd[0]),
      .w7_2_rdata (w_rd[1]),
      .w7_3_rdata (w_rd[2]),
      .w7_4_rdata (w_rd[3]),
      .w7_5_rdata (w_rd[4]),
      .w7_6_rdata (w_rd[5]),
      .w7_7_rdata (w_rd[6]),
      .w7_8_rdata (w_rd[7]),
      .w7_9_rdata (w_rd[8]),
      .w7_10_rdata(w_rd[9]),
      .fc7_result (fc7_result),
      .class_id   (class_id),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory models: data appears one cycle after the address.
   always @(posedge clk) begin
      f6_rdata <= f6_mem[f6_raddr];
      for (int k = 0; k < 10; k++) w_rd[k] <= w_mem[k][w7_raddr];
   end

   // Scoreboard check: on every done pulse pop the oldest expectation and compare.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: done=1 with no run outstanding");
         end else begin
            exp_t e;
            logic signed [ACC_W-1:0] s;
            e = sb.pop_front();
            for (int k = 0; k < 10; k++) begin
               s = fc7_result[k*ACC_W +: ACC_W];
               vectors++;
               if (int'(s) !== e.score[k]) begin
                  miscompares++;
                  $display("[TB] FAIL score%0d: got %0d expected %0d", k, int'(s), e.score[k]);
               end
            end
            vectors++;
            if (int'(class_id) !== e.cls) begin
               miscompares++;
               $display("[TB] FAIL class_id: got %0d expected %0d", class_id, e.cls);
            end
         end
      end
   end

   // Independent reference: dot products over the first N_IN words and a lowest-index argmax.
   task automatic push_expected();
      exp_t e;
      for (int k = 0; k < 10; k++) begin
         e.score[k] = 0;
         for (int i = 0; i < N_IN; i++) e.score[k] += int'(f6_mem[i]) * int'(w_mem[k][i]);
      end
      e.cls = 0;
      for (int k = 1; k < 10; k++) if (e.score[k] > e.score[e.cls]) e.cls = k;
      sb.push_back(e);
   endtask

   // Fill memories; words beyond N_IN hold a marker value that would corrupt scores if read.
   task automatic load_mem(input int act, input int wval [10]);
      for (int i = 0; i < 128; i++) begin
         f6_mem[i] = (i < N_IN) ? 8'(act) : 8'sd7;
         for (int k = 0; k < 10; k++) w_mem[k][i] = (i < N_IN) ? 8'(wval[k]) : 8'sd7;
      end
   endtask

   // Drive start in cycle c0 and observe cycles c1..c110 (bounded).
   task automatic applyStimulus(input bit inject, output int done_cyc, output int done_cnt,
                                output int busy_err, output int addr_err, output int zero_err);
      done_cyc = -1; done_cnt = 0; busy_err = 0; addr_err = 0; zero_err = 0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 110; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (f6_raddr !== w7_raddr) addr_err++;
         if (n <= N_IN && f6_raddr !== 7'(n - 1)) addr_err++;
         if (n > N_IN && n <= 95 && f6_raddr !== 7'd83) addr_err++;
         if (busy !== (n <= 95)) busy_err++;
         if (n <= 2 && fc7_result !== '0) zero_err++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (inject && (n == 10 || done === 1'b1)) start = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      vectors += 5;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      if (class_id !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_class: got %0d expected 0", class_id); end
      if (fc7_result !== '0) begin miscompares++; $display("[TB] FAIL reset_scores: got %h expected 0", fc7_result); end
      if (f6_raddr !== 7'd0 || w7_raddr !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", f6_raddr, w7_raddr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_all_ones();
      int wv [10];
      int dc, dn, be, ae, ze;
      logic signed [ACC_W-1:0] s;
      for (int k = 0; k < 10; k++) wv[k] = 1;
      load_mem(1, wv);
      push_expected();
      applyStimulus(1'b0, dc, dn, be, ae, ze);
      vectors += 6;
      if (dc !== 95) begin miscompares++; $display("[TB] FAIL ones_done_cycle: got %0d expected 95", dc); end
      if (dn !== 1) begin miscompares++; $display("[TB] FAIL ones_done_count: got %0d expected 1", dn); end
      if (be !== 0) begin miscompares++; $display("[TB] FAIL ones_busy: got %0d bad cycles expected 0", be); end
      if (ze !== 0) begin miscompares++; $display("[TB] FAIL ones_early_zero: got %0d bad cycles expected 0", ze); end
      if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL ones_sb_drain: got %0d left expected 0", sb.size()); sb.delete(); end
      s = fc7_result[0 +: ACC_W];
      if (int'(s) !== 84 || class_id !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL ones_hold: got %0d/%0d expected 84/0", int'(s), class_id);
      end
   endtask

   task automatic test_ramp();
      int wv [10];
      int dc, dn, be, ae, ze;
      for (int k = 0; k < 10; k++) wv[k] = k + 1;
      load_mem(1, wv);
      push_expected();
      applyStimulus(1'b0, dc, dn, be, ae, ze);
      vectors += 2;
      if (dc !== 95) begin miscompares++; $display("[TB] FAIL ramp_done_cycle: got %0d expected 95", dc); end
      if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL ramp_sb_drain: got %0d left expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_negative();
      int wv [10];
      int dc, dn, be, ae, ze;
      for (int k = 0; k < 10; k++) wv[k] = (k == 3) ? -128 : 0;
      load_mem(-128, wv);
      push_expected();
      applyStimulus(1'b0, dc, dn, be, ae, ze);
      for (int k = 0; k < 10; k++) wv[k] = (k == 6) ? -2 : -1;
      load_mem(5, wv);
      push_expected();
      applyStimulus(1'b0, dc, dn, be, ae, ze);
      vectors += 1;
      if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL neg_sb_drain: got %0d left expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_back_to_back();
      int wv [10];
      int dc, dn, be, ae, ze;
      for (int k = 0; k < 10; k++) wv[k] = (k * 7) % 5 - 2;
      load_mem(3, wv);
      push_expected();
      applyStimulus(1'b1, dc, dn, be, ae, ze);
      vectors += 5;
      if (ae !== 0) begin miscompares++; $display("[TB] FAIL addr_seq: got %0d bad cycles expected 0", ae); end
      if (dn !== 1) begin miscompares++; $display("[TB] FAIL ignored_start_done_count: got %0d expected 1", dn); end
      if (dc !== 95) begin miscompares++; $display("[TB] FAIL ignored_start_done_cycle: got %0d expected 95", dc); end
      if (be !== 0) begin miscompares++; $display("[TB] FAIL ignored_start_busy: got %0d bad cycles expected 0", be); end
      if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL b2b_sb_drain: got %0d left expected 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_mid_reset();
      int wv [10];
      int dc, dn, be, ae, ze;
      int late_done;
      for (int k = 0; k < 10; k++) wv[k] = 1;
      load_mem(1, wv);
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 40) rst_n = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      vectors += 4;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      if (fc7_result !== '0) begin miscompares++; $display("[TB] FAIL midrst_scores: got %h expected 0", fc7_result); end
      if (class_id !== 4'd0) begin miscompares++; $display("[TB] FAIL midrst_class: got %0d expected 0", class_id); end
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
      late_done = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) late_done++;
      end
      vectors++;
      if (late_done !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_resume: got %0d active cycles expected 0", late_done); end
      push_expected();
      applyStimulus(1'b0, dc, dn, be, ae, ze);
      vectors += 2;
      if (dc !== 95) begin miscompares++; $display("[TB] FAIL rerun_done_cycle: got %0d expected 95", dc); end
      if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL rerun_sb_drain: got %0d left expected 0", sb.size()); sb.delete(); end
   endtask

   // Test sequence: ramp runs before the mid-run reset so a nonzero class_id is visibly cleared.
   initial begin
      vectors     = 0;
      miscompares = 0;
      start       = 1'b0;
      rst_n       = 1'b0;
      test_reset();
      test_all_ones();
      test_negative();
      test_back_to_back();
      test_ramp();
      test_mid_reset();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fc7_layer.md
Name: fc7_layer

Overview:
- Fully-connected output layer (F7) of the LeNet datapath, directly downstream of the layer-7 weight ROM.
- Sweeps one shared read address over the F6 activation memory and the layer-7 weight ROM. Runs ten signed 8x8 multiply-accumulate lanes in parallel, one lane per output class.
- Then performs a sequential argmax and presents the ten class scores plus the winning class index to the result/output logic.

Parameters:
N_IN, 84, number of F6 activations and weight words per lane (ROM depth used)
ADDR_W, 7, address width of the F6 memory and the weight ROM
DATA_W, 8, signed activation/weight width
ACC_W, 24, signed accumulator width per class

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request to run one inference; accepted only in IDLE
busy  output  1  high in every state except IDLE
f6_raddr  output  ADDR_W  F6 activation read address
f6_rdata  input  DATA_W  signed activation, valid one cycle after f6_raddr
w7_raddr  output  ADDR_W  weight ROM read address, always equal to f6_raddr
w7_1_rdata..w7_10_rdata  input  DATA_W each (ten ports)  signed weight for class 0..9, valid one cycle after w7_raddr
fc7_result  output  10*ACC_W  class k score at bits [k*ACC_W +: ACC_W], k=0..9
class_id  output  4  index of maximum score, 0..9
done  output  1  one-cycle pulse, results and class_id final

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, addresses 0, all accumulators 0, class_id 0, done 0, busy 0, read-valid pipe flag 0. Reset mid-operation aborts immediately; no partial result survives.
- States: IDLE, RUN, DRAIN, ARGMAX, DONE.
- IDLE: start=1 -> clear all accumulators and the address counter, go RUN. start in any other state is ignored, including DONE.
- RUN: registered counter drives f6_raddr = w7_raddr = 0..N_IN-1, one per cycle. A valid flag delayed one cycle marks returning data. After address N_IN-1 is issued, go DRAIN. Addresses hold at N_IN-1 until the next run.
- Accumulate on every cycle the delayed valid flag is high: acc_k <= acc_k + sext(f6_rdata * w7_(k+1)_rdata).
  - Product is signed 16-bit, sign-extended to ACC_W.
  - Two's-complement wrap, no saturation; ACC_W=24 cannot overflow for N_IN=84.
- DRAIN: one cycle; the final product is accumulated; go ARGMAX.
- ARGMAX: on entry best=acc_0, idx=0. Then compare index 1..9, one per cycle (9 cycles); replace only if acc_k > best (signed, strict), so ties keep the lower index. Go DONE.
- DONE: one cycle; done=1, class_id final; go IDLE.
- Timing, with start sampled in cycle c0:
  - RUN occupies c1..c84 (address k in cycle c(k+1)).
  - DRAIN is c85; ARGMAX is c86..c94; done=1 in c95 (N_IN+11).
  - busy=1 in c1..c95.
- fc7_result is driven by the accumulators; it reads 0 from c1 until accumulation begins.
- class_id updates only in ARGMAX.
- Both fc7_result and class_id hold their values after done until the next accepted start.

Test Plan:
- All activations 1, all weights 1 (ROM model with 1-cycle latency) -> every score 84, class_id 0 (tie keeps lowest), done exactly in c95, busy c1..c95.
- Activations 1, weight for class k = k+1 -> scores 84,168,...,840, class_id 9.
- Activations -128, weights -128 on class 3, 0 elsewhere -> score3 = 1376256, others 0, class_id 3. Activations 5, weights -1 everywhere except class 6 = -2 -> all negative, class_id 0 (ties at -420 over -840).
- Address check: f6_raddr == w7_raddr every cycle; sequence 0..83 in c1..c84; start pulses at c10 and in the DONE cycle are ignored (no restart, done once).
- rst_n low at c40 for one cycle -> next cycle busy 0, scores 0, class_id 0, no done. A fresh start then reproduces the first scenario's results exactly.
